// File: rtl/kalman_gain_semipar_pkg.sv
// kalman_gain_semipar_pkg
//   Shared fixed-point defaults and controller state encoding for the Kalman
//   gain block and its sequential divider.
//   FXP_N    : default data word width (signed two's complement)
//   FXP_FRAC : default fractional bits (1.0 = 2**FXP_FRAC)
//   NUM_MUL  : number of shared multiplier lanes
//   kg_state_t : KG_IDLE .. KG_DIV1_WAIT controller states
package kalman_gain_semipar_pkg;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;
    localparam int NUM_MUL  = 4;

    // KG_DIV1_GO keeps the encoding complete; the controller folds the second
    // divide launch into the DIV0_WAIT exit so it is never entered.
    typedef enum logic [3:0] {
        KG_IDLE      = 4'd0,
        KG_MUL0      = 4'd1,
        KG_SUM0      = 4'd2,
        KG_MUL1      = 4'd3,
        KG_SUM1      = 4'd4,
        KG_DIV0_GO   = 4'd5,
        KG_DIV0_WAIT = 4'd6,
        KG_DIV1_GO   = 4'd7,
        KG_DIV1_WAIT = 4'd8
    } kg_state_t;

endpackage

// File: rtl/kalman_gain_semipar_fxp_div_seq.sv
// fxp_div_seq
//   Restoring signed sequential divider: q = (num * 2**FRAC) / den, computed
//   on magnitudes, truncated toward zero, sign = sign(num) ^ sign(den).
//   One quotient bit per clock, N+FRAC iterations. start sampled at edge k
//   gives done (one-cycle pulse) together with q/ovf after edge k+N+FRAC.
//   Build option KG_SAT_EN: defined -> out-of-range quotients clamp to the
//   nearest N-bit bound; undefined -> the low N bits are kept (wrap).
//   ovf flags an out-of-range quotient in both builds.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load num/den and begin a divide
//   num, den   : signed N-bit operands
//   q          : signed N-bit quotient, ovf : quotient out of range
//   done       : one-cycle pulse when q/ovf are updated
module fxp_div_seq import kalman_gain_semipar_pkg::*; #(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic [N-1:0] q,
    output logic         done,
    output logic         ovf
);
    localparam int QW = N + FRAC;
    localparam int CW = $clog2(QW + 1);
    // largest magnitudes representable for a positive / negative result
    localparam logic [QW-1:0] MAG_POS = QW'((64'd1 << (N - 1)) - 64'd1);
    localparam logic [QW-1:0] MAG_NEG = QW'(64'd1 << (N - 1));
`ifdef KG_SAT_EN
    localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};
`endif

    // dvd shifts dividend bits out of the top and quotient bits into the bottom
    logic [QW-1:0] dvd;
    logic [N-1:0]  rem;
    logic [N-1:0]  den_mag;
    logic          neg;
    logic [CW-1:0] cnt;
    logic          run;

    logic [N-1:0]  num_mag_in, den_mag_in;
    logic [N:0]    rem_sh;
    logic          fits;
    logic [N-1:0]  rem_nx;
    logic [QW-1:0] dvd_nx;
    logic          q_ovf;
    logic [N-1:0]  q_low;
    logic [N-1:0]  q_fin;

    // magnitude of -2**(N-1) is 2**(N-1), which still fits N unsigned bits
    assign num_mag_in = num[N-1] ? (~num + 1'b1) : num;
    assign den_mag_in = den[N-1] ? (~den + 1'b1) : den;

    always_comb begin
        rem_sh = {rem, dvd[QW-1]};
        fits   = (rem_sh >= {1'b0, den_mag});
        rem_nx = fits ? N'(rem_sh - {1'b0, den_mag}) : rem_sh[N-1:0];
        dvd_nx = {dvd[QW-2:0], fits};
        // dvd_nx holds the full quotient magnitude on the last iteration
        q_ovf  = neg ? (dvd_nx > MAG_NEG) : (dvd_nx > MAG_POS);
        q_low  = neg ? (~dvd_nx[N-1:0] + 1'b1) : dvd_nx[N-1:0];
`ifdef KG_SAT_EN
        q_fin  = q_ovf ? (neg ? Q_MIN : Q_MAX) : q_low;
`else
        q_fin  = q_low;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd     <= '0;
            rem     <= '0;
            den_mag <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            run     <= 1'b0;
            q       <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                dvd     <= {num_mag_in, {FRAC{1'b0}}};
                rem     <= '0;
                den_mag <= den_mag_in;
                neg     <= num[N-1] ^ den[N-1];
                cnt     <= CW'(QW);
                run     <= 1'b1;
            end else if (run) begin
                rem <= rem_nx;
                dvd <= dvd_nx;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                    q    <= q_fin;
                    ovf  <= q_ovf;
                end
            end
        end
    end

endmodule

// File: rtl/kalman_gain_semipar.sv
// kalman_gain_semipar
//   Kalman gain for a 2-state / scalar-measurement filter:
//     u = P_prior * H^T, s = H*u + r, K = u / s   (signed fixed point)
//   Four shared multiplier lanes and one shared sequential divider
//   (fxp_div_seq) sequenced by a start/done controller.
//   Products and sums are kept at 2N bits; N-bit results are bits
//   [FRAC+N-1:FRAC] of the 2N-bit sum (no rounding).
//   Build option KG_SAT_EN selects clamping (defined) or wrapping (undefined)
//   of out-of-range gains; sat reports the overflow either way.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : one-cycle request, ignored while busy
//   P_PRIOR00..P_PRIOR11  : prior covariance (held stable until done)
//   h0, h1, r             : measurement row and noise variance
//   done                  : one-cycle pulse, K0/K1/S_INNOV/div_err/sat valid
//   busy                  : run in progress
//   K0, K1                : gain, S_INNOV : innovation variance s
//   div_err               : s <= 0 on the last run (no divide, K = 0)
//   sat                   : a quotient overflowed on the last run
module kalman_gain_semipar import kalman_gain_semipar_pkg::*; #(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [N-1:0] P_PRIOR00,
    input  logic signed [N-1:0] P_PRIOR01,
    input  logic signed [N-1:0] P_PRIOR10,
    input  logic signed [N-1:0] P_PRIOR11,
    input  logic signed [N-1:0] h0,
    input  logic signed [N-1:0] h1,
    input  logic signed [N-1:0] r,
    output logic                done,
    output logic                busy,
    output logic signed [N-1:0] K0,
    output logic signed [N-1:0] K1,
    output logic signed [N-1:0] S_INNOV,
    output logic                div_err,
    output logic                sat
);

    kg_state_t state;

    logic [NUM_MUL-1:0][N-1:0]   mul_a, mul_b;
    logic [NUM_MUL-1:0][2*N-1:0] mul_p;
    logic [NUM_MUL-1:0][2*N-1:0] m;

    logic [N-1:0]   u0, u1, s_reg, k0_q;
    logic           ovf0;
    logic [2*N-1:0] r_2n;
    logic [2*N-1:0] sum_u0, sum_u1, sum_s;

    logic           s_pos;
    logic           div_start, div_done, div_ovf;
    logic [N-1:0]   div_num, div_q;

    function automatic logic [2*N-1:0] fxp_mul(input logic signed [N-1:0] a,
                                               input logic signed [N-1:0] b);
        logic signed [2*N-1:0] ax, bx;
        ax = a;
        bx = b;
        return ax * bx;
    endfunction

    function automatic logic [2*N-1:0] fxp_add(input logic [2*N-1:0] a,
                                               input logic [2*N-1:0] b);
        return a + b;
    endfunction

    function automatic logic [N-1:0] fxp_trunc(input logic [2*N-1:0] v);
        return v[FRAC+N-1:FRAC];
    endfunction

    // Operand routing for the shared multipliers. Lanes are idle (zero)
    // outside the two multiply phases; lanes 2/3 are unused in MUL1.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == KG_MUL0) begin
            mul_a = {h1, h0, h1, h0};
            mul_b = {P_PRIOR11, P_PRIOR10, P_PRIOR01, P_PRIOR00};
        end else if (state == KG_MUL1) begin
            mul_a[0] = h0;
            mul_b[0] = u0;
            mul_a[1] = h1;
            mul_b[1] = u1;
        end
    end

    for (genvar g = 0; g < NUM_MUL; g++) begin : g_mul
        assign mul_p[g] = fxp_mul(mul_a[g], mul_b[g]);
    end

    // r joins the 2N-bit sum already scaled by 2**FRAC
    assign r_2n   = {{N{r[N-1]}}, r} << FRAC;
    assign sum_u0 = fxp_add(m[0], m[1]);
    assign sum_u1 = fxp_add(m[2], m[3]);
    assign sum_s  = fxp_add(sum_u0, r_2n);

    assign s_pos  = ~s_reg[N-1] & (|s_reg);

    // First divide launches from DIV0_GO; the second is launched on the
    // same edge that captures the first quotient, saving a GO cycle.
    assign div_start = ((state == KG_DIV0_GO)   && s_pos) ||
                       ((state == KG_DIV0_WAIT) && div_done);
    assign div_num   = (state == KG_DIV0_GO) ? u0 : u1;

    fxp_div_seq #(.N(N), .FRAC(FRAC)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (s_reg),
        .q     (div_q),
        .done  (div_done),
        .ovf   (div_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= KG_IDLE;
            m       <= '0;
            u0      <= '0;
            u1      <= '0;
            s_reg   <= '0;
            k0_q    <= '0;
            ovf0    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            K0      <= '0;
            K1      <= '0;
            S_INNOV <= '0;
            div_err <= 1'b0;
            sat     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                KG_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= KG_MUL0;
                    end
                end
                KG_MUL0: begin
                    m     <= mul_p;
                    state <= KG_SUM0;
                end
                KG_SUM0: begin
                    u0    <= fxp_trunc(sum_u0);
                    u1    <= fxp_trunc(sum_u1);
                    state <= KG_MUL1;
                end
                KG_MUL1: begin
                    m     <= mul_p;
                    state <= KG_SUM1;
                end
                KG_SUM1: begin
                    s_reg <= fxp_trunc(sum_s);
                    state <= KG_DIV0_GO;
                end
                KG_DIV0_GO: begin
                    if (!s_pos) begin
                        // non-positive innovation variance: skip both divides
                        K0      <= '0;
                        K1      <= '0;
                        S_INNOV <= s_reg;
                        div_err <= 1'b1;
                        sat     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= KG_IDLE;
                    end else begin
                        state <= KG_DIV0_WAIT;
                    end
                end
                KG_DIV0_WAIT: begin
                    if (div_done) begin
                        k0_q  <= div_q;
                        ovf0  <= div_ovf;
                        state <= KG_DIV1_WAIT;
                    end
                end
                KG_DIV1_WAIT: begin
                    if (div_done) begin
                        K0      <= k0_q;
                        K1      <= div_q;
                        S_INNOV <= s_reg;
                        div_err <= 1'b0;
                        sat     <= ovf0 | div_ovf;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= KG_IDLE;
                    end
                end
                default: state <= KG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_gain_semipar.sv
// tb_kalman_gain_semipar
//   Directed and randomized runs of kalman_gain_semipar against an
//   arithmetic reference model of the gain equations.
//   Honours KG_SAT_EN for the expected overflow behaviour.
module tb_kalman_gain_semipar;
    localparam int N    = 16;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic signed [N-1:0] p00 = '0, p01 = '0, p10 = '0, p11 = '0;
    logic signed [N-1:0] h0 = '0, h1 = '0, r = '0;
    logic done, busy, div_err, sat;
    logic signed [N-1:0] K0, K1, S_INNOV;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        longint s, k0, k1, err, sat, lat;
    } exp_t;

    always #5 clk = ~clk;

    kalman_gain_semipar dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .P_PRIOR00 (p00),
        .P_PRIOR01 (p01),
        .P_PRIOR10 (p10),
        .P_PRIOR11 (p11),
        .h0        (h0),
        .h1        (h1),
        .r         (r),
        .done      (done),
        .busy      (busy),
        .K0        (K0),
        .K1        (K1),
        .S_INNOV   (S_INNOV),
        .div_err   (div_err),
        .sat       (sat)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint wrap_n(input longint v);
        return longint'(shortint'(v));
    endfunction

    function automatic longint wrap_2n(input longint v);
        return longint'(int'(v));
    endfunction

    // gain after range handling for this build
    function automatic longint fit(input longint q);
`ifdef KG_SAT_EN
        if (q > 32767) return 32767;
        if (q < -32768) return -32768;
        return q;
`else
        return wrap_n(q);
`endif
    endfunction

    function automatic exp_t model(input longint a00, input longint a01, input longint a10,
                                   input longint a11, input longint g0, input longint g1,
                                   input longint rr);
        exp_t e;
        longint u0, u1, q0, q1;
        u0  = wrap_n(wrap_2n(a00 * g0 + a01 * g1) >>> FRAC);
        u1  = wrap_n(wrap_2n(a10 * g0 + a11 * g1) >>> FRAC);
        e.s = wrap_n(wrap_2n(g0 * u0 + g1 * u1 + rr * (64'sd1 <<< FRAC)) >>> FRAC);
        if (e.s <= 0) begin
            e.k0 = 0; e.k1 = 0; e.err = 1; e.sat = 0; e.lat = 5;
            return e;
        end
        // SV signed division truncates toward zero, as required
        q0    = (u0 * (64'sd1 <<< FRAC)) / e.s;
        q1    = (u1 * (64'sd1 <<< FRAC)) / e.s;
        e.k0  = fit(q0);
        e.k1  = fit(q1);
        e.err = 0;
        e.sat = (q0 > 32767 || q0 < -32768 || q1 > 32767 || q1 < -32768) ? 1 : 0;
        e.lat = 7 + 2 * (N + FRAC);
        return e;
    endfunction

    function automatic longint rnd(input int lo, input int hi);
        return longint'(lo) + longint'($urandom_range(hi - lo));
    endfunction

    // One run: drive inputs, pulse start, wait (bounded) for done, compare.
    // glitch_at pulses start again that many cycles into the run.
    // b2b leaves the bench in the done cycle so the next run starts at once.
    task automatic run(input string tag, input longint a00, input longint a01,
                       input longint a10, input longint a11, input longint g0,
                       input longint g1, input longint rr, input int glitch_at,
                       input bit b2b, output int lat);
        exp_t e;
        p00 = N'(a00); p01 = N'(a01); p10 = N'(a10); p11 = N'(a11);
        h0  = N'(g0);  h1  = N'(g1);  r   = N'(rr);
        e = model(p00, p01, p10, p11, h0, h1, r);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        chk({tag, ".busy"}, busy, 1);
        while (!done && lat < 200) begin
            @(posedge clk); #1 lat++;
            start = (lat == glitch_at);
        end
        start = 1'b0;
        chk({tag, ".latency"}, lat, e.lat);
        chk({tag, ".s_innov"}, S_INNOV, e.s);
        chk({tag, ".k0"}, K0, e.k0);
        chk({tag, ".k1"}, K1, e.k1);
        chk({tag, ".div_err"}, div_err, e.err);
        chk({tag, ".sat"}, sat, e.sat);
        if (!b2b) begin
            @(posedge clk); #1;
            chk({tag, ".done_pulse"}, done, 0);
            chk({tag, ".busy_end"}, busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int ndone;

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.done", done, 0);
        chk("rst.busy", busy, 0);
        chk("rst.k0", K0, 0);
        chk("rst.k1", K1, 0);
        chk("rst.s_innov", S_INNOV, 0);
        chk("rst.div_err", div_err, 0);
        chk("rst.sat", sat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity covariance, unit measurement
        run("t1", 256, 0, 0, 256, 256, 0, 256, -1, 1'b0, lat);
        chk("t1.lat55", lat, 55);
        chk("t1.s512", S_INNOV, 512);
        chk("t1.k0_128", K0, 128);
        chk("t1.k1_0", K1, 0);

        // outputs hold between runs
        repeat (6) @(posedge clk);
        #1;
        chk("hold.k0", K0, 128);
        chk("hold.s", S_INNOV, 512);

        // correlated covariance, r = 0
        run("t2", 512, 128, 128, 256, 256, 0, 0, -1, 1'b0, lat);
        chk("t2.s512", S_INNOV, 512);
        chk("t2.k0_256", K0, 256);
        chk("t2.k1_64", K1, 64);
        chk("t2.err0", div_err, 0);
        chk("t2.sat0", sat, 0);

        // s = 0: no divide, early done
        run("t3", 0, 0, 0, 0, 256, 256, 0, -1, 1'b0, lat);
        chk("t3.lat5", lat, 5);
        chk("t3.err1", div_err, 1);
        chk("t3.k0_0", K0, 0);
        chk("t3.k1_0", K1, 0);

        // tiny s: quotient overflow
        run("t4", 1000, 0, 0, -995, 256, 256, 0, -1, 1'b0, lat);
        chk("t4.s5", S_INNOV, 5);
        chk("t4.sat1", sat, 1);
`ifdef KG_SAT_EN
        chk("t4.k0_clamp", K0, 32767);
        chk("t4.k1_clamp", K1, -32768);
`else
        chk("t4.k0_wrap", K0, -14336);
        chk("t4.k1_wrap", K1, 14592);
`endif

        // start while busy is ignored; start during done launches a new run
        run("t5a", 256, 0, 0, 256, 256, 0, 256, 10, 1'b1, lat);
        chk("t5a.lat55", lat, 55);
        run("t5b", 512, 128, 128, 256, 256, 0, 0, -1, 1'b0, lat);
        chk("t5b.lat55", lat, 55);

        // reset mid-run aborts without done
        p00 = 16'sd256; p01 = '0; p10 = '0; p11 = 16'sd256;
        h0 = 16'sd256; h1 = '0; r = 16'sd256;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6.rst_done", done, 0);
        chk("t6.rst_busy", busy, 0);
        chk("t6.rst_k0", K0, 0);
        chk("t6.rst_k1", K1, 0);
        chk("t6.rst_s", S_INNOV, 0);
        chk("t6.rst_sat", sat, 0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t6.no_done", ndone, 0);
        run("t6r", 256, 0, 0, 256, 256, 0, 256, -1, 1'b0, lat);
        chk("t6r.k0_128", K0, 128);
        chk("t6r.s512", S_INNOV, 512);

        // randomized runs against the model
        for (int i = 0; i < 10; i++) begin
            run($sformatf("rnd%0d", i),
                rnd(-1024, 1023), rnd(-1024, 1023), rnd(-1024, 1023), rnd(-1024, 1023),
                rnd(-512, 511), rnd(-512, 511), rnd(0, 1023), -1, 1'b0, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
